game_sequencer: RTL and testbench
=================================

// Module: game_sequencer
// PURPOSE
//   Central game controller for the dinosaur runner. Sequences the game through
//   idle, arm, run and game-over states. Applies start requests only at a vertical-
//   blanking boundary and detects dinosaur/cactus collisions. Schedules the scroll
//   speed and keeps the score. Drives game_status and speed into the jump, ground
//   and cactus blocks; takes vs and the per-layer pixel hits back from the VGA path.
// PARAMETERS
//   SPEED_MIN        1     speed loaded on reset and on entry to RUN
//   SPEED_MAX        15    speed saturation ceiling (fits 4 bits)
//   FRAMES_PER_STEP  600   RUN frames between speed increments (>=2)
//   CRASH_HOLD       60    frames in OVER during which start is ignored
//   SCORE_W          16    score width
// PORTS
//   CLK          in   1        system clock
//   RESET_N      in   1        asynchronous, active-low reset
//   vs           in   1        VGA vsync; 1->0 edge marks a frame boundary
//   start        in   1        debounced start button, active high, level
//   px_dinosaur  in   1        current pixel belongs to dinosaur
//   px_cactus    in   1        current pixel belongs to cactus
//   game_status  out  1        1 while state==RUN
//   crashed      out  1        1 while state==OVER
//   speed        out  4        scroll speed for ground/cactus
//   score        out  SCORE_W  frames survived in current/last run
//   frame_tick   out  1        one-CLK pulse per frame boundary
// BEHAVIOUR
//   Reset (RESET_N=0, async): state=IDLE, game_status=0, crashed=0, speed=SPEED_MIN,
//     score=0, frame_tick=0, all counters and edge registers 0.
//   Edges: vs_d and start_d are registered copies. frame_tick is a registered pulse:
//     high the cycle after (vs_d & ~vs). start_rise = start & ~start_d. Only a rising
//     edge acts, so a held button never causes auto-restart.
//   hit = px_dinosaur & px_cactus, sampled every CLK.
//   States: IDLE=0, ARMED=1, RUN=2, OVER=3. All outputs registered; a transition is
//     visible the cycle after its cause.
//   IDLE  : start_rise -> ARMED.
//   ARMED : frame_tick -> RUN. On that entry: score=0, speed=SPEED_MIN, step_cnt=0.
//     start_rise ignored.
//   RUN   : hit -> OVER, hold_cnt=CRASH_HOLD. Else on frame_tick: score+1, saturating
//     at all-ones. step_cnt+1. When step_cnt==FRAMES_PER_STEP-1: step_cnt=0 and
//     speed+1, saturating at SPEED_MAX. start_rise ignored.
//   OVER  : hold_cnt-1 per frame_tick, stopping at 0. When hold_cnt==0 and
//     start_rise -> ARMED. score and speed frozen until RUN is re-entered.
//   Simultaneous events:
//     - hit and frame_tick in RUN: hit wins; score, step_cnt and speed unchanged.
//     - start_rise and hit in RUN: go to OVER.
//     - start_rise in the same cycle hold_cnt reaches 0: ignored.
//   Reset mid-run forces IDLE immediately; the pending run is discarded.
//   Overflow rules:
//     - step_cnt width: $clog2(FRAMES_PER_STEP).
//     - hold_cnt width: $clog2(CRASH_HOLD+1).
//     - no wrap on score or speed.
// STRUCTURE
//   game_pkg: state enum (IDLE/ARMED/RUN/OVER), SPEED_W=4, default SPEED_MIN/MAX.
//   Sub-module edge_pulse (registered rising/falling pulse) is instantiated twice:
//     vs falling edge and start rising edge.
//   Rest is one FSM plus three counters in this file.
// TESTING
//   1 Reset: RESET_N=0 mid-RUN with speed=5 -> same cycle state=IDLE, speed=1,
//     score=0, game_status=0.
//   2 Start: start rise in IDLE -> ARMED next CLK; game_status rises 1 CLK after
//     the next vs 1->0 edge.
//   3 Speed schedule: FRAMES_PER_STEP=4, run 60 frames, no hit -> speed steps every
//     4 frames and holds at 15; score=60.
//   4 Collision/tick: hit coincident with frame_tick at score=9 -> OVER, crashed=1,
//     score stays 9.
//   5 Crash hold: CRASH_HOLD=3, start rise after 2 frames -> ignored. Start rise
//     after 3 frames -> ARMED; score 9 kept until RUN, then 0.
//   6 Held start: start held high through IDLE->RUN->crash -> stays OVER; no restart.

Source files
------------

// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
// Module  : game_pkg
// Purpose : Shared types and defaults for the dinosaur-runner game controller.
//           Defines the sequencer state encoding, the speed bus width and the
//           default speed limits.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package game_pkg;

    localparam int SPEED_W           = 4;
    localparam int SPEED_MIN_DEFAULT = 1;
    localparam int SPEED_MAX_DEFAULT = 15;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2,
        ST_OVER  = 2'd3
    } game_state_t;

endpackage : game_pkg
`default_nettype wire

// File: rtl/edge_pulse.sv
`default_nettype none
// ============================================================================
// Module  : edge_pulse
// Purpose : Single-signal edge detector. Keeps a registered copy of i_sig and
//           flags a rising (RISING=1) or falling (RISING=0) transition. With
//           REGISTERED=1 the pulse is re-timed by one flop; otherwise it is the
//           combinational compare against the delayed copy.
// Ports   : clk     - system clock
//           rst_n   - asynchronous active-low reset
//           i_sig   - level to watch
//           o_pulse - one-cycle pulse per detected edge
// Revision: 1.0 - initial release
// ============================================================================
module edge_pulse #(
    parameter bit RISING     = 1'b1,
    parameter bit REGISTERED = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_sig,
    output logic o_pulse
);

    logic r_sig_d;
    logic w_edge;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sig_d <= 1'b0;
        end else begin
            r_sig_d <= i_sig;
        end
    end

    assign w_edge = RISING ? (i_sig & ~r_sig_d) : (r_sig_d & ~i_sig);

    generate
        if (REGISTERED) begin : g_reg
            logic r_pulse;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_pulse <= 1'b0;
                end else begin
                    r_pulse <= w_edge;
                end
            end
            assign o_pulse = r_pulse;
        end else begin : g_comb
            assign o_pulse = w_edge;
        end
    endgenerate

endmodule : edge_pulse
`default_nettype wire

// File: rtl/game_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : game_sequencer
// Purpose : Central controller of the dinosaur runner. Walks IDLE -> ARMED ->
//           RUN -> OVER, starts a run only on a frame boundary, detects the
//           dinosaur/cactus overlap, schedules scroll speed and counts score.
// Ports   : clk            - system clock
//           rst_n          - asynchronous active-low reset
//           i_vs           - VGA vsync, 1->0 marks a frame boundary
//           i_start        - debounced start button (level, active high)
//           i_px_dinosaur  - current pixel belongs to the dinosaur
//           i_px_cactus    - current pixel belongs to a cactus
//           o_game_status  - 1 while running
//           o_crashed      - 1 while in game-over
//           o_speed        - scroll speed for ground/cactus blocks
//           o_score        - frames survived in the current/last run
//           o_frame_tick   - one-clock pulse per frame boundary
// Revision: 1.0 - initial release
// ============================================================================
module game_sequencer
    import game_pkg::*;
#(
    parameter int SPEED_MIN       = SPEED_MIN_DEFAULT,
    parameter int SPEED_MAX       = SPEED_MAX_DEFAULT,
    parameter int FRAMES_PER_STEP = 600,
    parameter int CRASH_HOLD      = 60,
    parameter int SCORE_W         = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_vs,
    input  logic               i_start,
    input  logic               i_px_dinosaur,
    input  logic               i_px_cactus,
    output logic               o_game_status,
    output logic               o_crashed,
    output logic [SPEED_W-1:0] o_speed,
    output logic [SCORE_W-1:0] o_score,
    output logic               o_frame_tick
);

    localparam int C_STEP_W = $clog2(FRAMES_PER_STEP);
    localparam int C_HOLD_W = $clog2(CRASH_HOLD + 1);

    localparam logic [SPEED_W-1:0]  C_SPEED_MIN = SPEED_W'(SPEED_MIN);
    localparam logic [SPEED_W-1:0]  C_SPEED_MAX = SPEED_W'(SPEED_MAX);
    localparam logic [C_STEP_W-1:0] C_STEP_LAST = C_STEP_W'(FRAMES_PER_STEP - 1);
    localparam logic [C_HOLD_W-1:0] C_HOLD_INIT = C_HOLD_W'(CRASH_HOLD);

    game_state_t         r_state;
    logic                r_game_status;
    logic                r_crashed;
    logic [SPEED_W-1:0]  r_speed;
    logic [SCORE_W-1:0]  r_score;
    logic [C_STEP_W-1:0] r_step_cnt;
    logic [C_HOLD_W-1:0] r_hold_cnt;

    logic w_frame_tick;
    logic w_start_rise;
    logic w_hit;

    // Frame boundary: registered pulse one cycle after vsync falls.
    edge_pulse #(
        .RISING     (1'b0),
        .REGISTERED (1'b1)
    ) u_vs_edge (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_sig   (i_vs),
        .o_pulse (w_frame_tick)
    );

    // Start press: acts in the same cycle the button is first seen high, so a
    // held button can never produce a second press.
    edge_pulse #(
        .RISING     (1'b1),
        .REGISTERED (1'b0)
    ) u_start_edge (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_sig   (i_start),
        .o_pulse (w_start_rise)
    );

    assign w_hit = i_px_dinosaur & i_px_cactus;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_game_status <= 1'b0;
            r_crashed     <= 1'b0;
            r_speed       <= C_SPEED_MIN;
            r_score       <= '0;
            r_step_cnt    <= '0;
            r_hold_cnt    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start_rise) begin
                        r_state <= ST_ARMED;
                    end
                end

                ST_ARMED: begin
                    if (w_frame_tick) begin
                        r_state       <= ST_RUN;
                        r_game_status <= 1'b1;
                        r_score       <= '0;
                        r_speed       <= C_SPEED_MIN;
                        r_step_cnt    <= '0;
                    end
                end

                ST_RUN: begin
                    // A collision takes priority over the frame update, so the
                    // crash frame is never credited to the score.
                    if (w_hit) begin
                        r_state       <= ST_OVER;
                        r_game_status <= 1'b0;
                        r_crashed     <= 1'b1;
                        r_hold_cnt    <= C_HOLD_INIT;
                    end else if (w_frame_tick) begin
                        if (r_score != '1) begin
                            r_score <= r_score + 1'b1;
                        end
                        if (r_step_cnt == C_STEP_LAST) begin
                            r_step_cnt <= '0;
                            if (r_speed != C_SPEED_MAX) begin
                                r_speed <= r_speed + 1'b1;
                            end
                        end else begin
                            r_step_cnt <= r_step_cnt + 1'b1;
                        end
                    end
                end

                ST_OVER: begin
                    // Restart is judged on the hold count before this cycle's
                    // decrement, so a press on the expiring frame is ignored.
                    if ((r_hold_cnt == '0) && w_start_rise) begin
                        r_state   <= ST_ARMED;
                        r_crashed <= 1'b0;
                    end else if (w_frame_tick && (r_hold_cnt != '0)) begin
                        r_hold_cnt <= r_hold_cnt - 1'b1;
                    end
                end

                default: begin
                    r_state       <= ST_IDLE;
                    r_game_status <= 1'b0;
                    r_crashed     <= 1'b0;
                end
            endcase
        end
    end

    assign o_game_status = r_game_status;
    assign o_crashed     = r_crashed;
    assign o_speed       = r_speed;
    assign o_score       = r_score;
    assign o_frame_tick  = w_frame_tick;

endmodule : game_sequencer
`default_nettype wire

// File: tb/tb_game_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_game_sequencer
// Purpose : Self-checking bench for game_sequencer. Stimulus pushes expected
//           output snapshots into a scoreboard queue; a monitor pops them on
//           the falling clock edge and compares against the DUT outputs.
// Ports   : none
// Revision: 1.0 - initial release
// ============================================================================
module tb_game_sequencer;

    localparam int C_FPS     = 4;
    localparam int C_HOLD    = 3;
    localparam int C_SCORE_W = 16;

    logic                 clk;
    logic                 rst_n;
    logic                 r_vs;
    logic                 r_start;
    logic                 r_px_dino;
    logic                 r_px_cactus;
    logic                 w_game_status;
    logic                 w_crashed;
    logic [3:0]           w_speed;
    logic [C_SCORE_W-1:0] w_score;
    logic                 w_frame_tick;

    game_sequencer #(
        .SPEED_MIN       (1),
        .SPEED_MAX       (15),
        .FRAMES_PER_STEP (C_FPS),
        .CRASH_HOLD      (C_HOLD),
        .SCORE_W         (C_SCORE_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_vs          (r_vs),
        .i_start       (r_start),
        .i_px_dinosaur (r_px_dino),
        .i_px_cactus   (r_px_cactus),
        .o_game_status (w_game_status),
        .o_crashed     (w_crashed),
        .o_speed       (w_speed),
        .o_score       (w_score),
        .o_frame_tick  (w_frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string                name;
        logic                 gs;
        logic                 cr;
        logic [3:0]           sp;
        logic [C_SCORE_W-1:0] sc;
        logic                 chk_tick;
        logic                 tick;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model of a running game.
    int m_score;
    int m_speed;
    int m_step;

    // Monitor: compares one queued expectation per falling edge.
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            exp_t e;
            bit   ok;
            e  = sb.pop_front();
            ok = (w_game_status === e.gs) && (w_crashed === e.cr) &&
                 (w_speed === e.sp) && (w_score === e.sc) &&
                 (!e.chk_tick || (w_frame_tick === e.tick));
            n_checks++;
            if (ok) begin
                n_pass++;
            end else begin
                $display("FAIL %s: got gs=%0d cr=%0d speed=%0d score=%0d tick=%0d, want gs=%0d cr=%0d speed=%0d score=%0d tick=%0d",
                         e.name, w_game_status, w_crashed, w_speed, w_score, w_frame_tick,
                         e.gs, e.cr, e.sp, e.sc, e.chk_tick ? e.tick : w_frame_tick);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic gs, input logic cr,
                       input int sp, input int sc,
                       input logic chk_tick = 1'b0, input logic tick = 1'b0);
        exp_t e;
        e.name     = name;
        e.gs       = gs;
        e.cr       = cr;
        e.sp       = 4'(sp);
        e.sc       = C_SCORE_W'(sc);
        e.chk_tick = chk_tick;
        e.tick     = tick;
        sb.push_back(e);
        @(negedge clk);
        #1;
    endtask

    // One vsync falling edge; outputs reflect the frame after this returns.
    // with_start raises start on the cycle the frame is acted on.
    task automatic frame(input bit with_start, input bit with_hit);
        r_vs = 1'b0;
        step();
        r_vs = 1'b1;
        if (with_start) r_start = 1'b1;
        if (with_hit) begin
            r_px_dino   = 1'b1;
            r_px_cactus = 1'b1;
        end
        step();
        r_px_dino   = 1'b0;
        r_px_cactus = 1'b0;
    endtask

    task automatic press();
        r_start = 1'b1;
        step();
        r_start = 1'b0;
    endtask

    task automatic hit();
        r_px_dino   = 1'b1;
        r_px_cactus = 1'b1;
        step();
        r_px_dino   = 1'b0;
        r_px_cactus = 1'b0;
    endtask

    task automatic model_enter_run();
        m_score = 0;
        m_speed = 1;
        m_step  = 0;
    endtask

    task automatic run_frame();
        frame(1'b0, 1'b0);
        m_score++;
        if (m_step == C_FPS - 1) begin
            m_step = 0;
            if (m_speed < 15) m_speed++;
        end else begin
            m_step++;
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        r_vs        = 1'b1;
        r_start     = 1'b0;
        r_px_dino   = 1'b0;
        r_px_cactus = 1'b0;
        model_enter_run();

        repeat (2) step();
        chk("reset_state", 1'b0, 1'b0, 1, 0, 1'b1, 1'b0);
        rst_n = 1'b1;
        step();

        // Start in IDLE -> ARMED; run begins one cycle after the vs tick.
        press();
        chk("armed_not_running", 1'b0, 1'b0, 1, 0);
        r_vs = 1'b0;
        step();
        chk("armed_tick_pending", 1'b0, 1'b0, 1, 0, 1'b1, 1'b1);
        r_vs = 1'b1;
        step();
        chk("run_entry", 1'b1, 1'b0, 1, 0, 1'b1, 1'b0);
        model_enter_run();

        // Speed schedule over 60 frames.
        for (int i = 0; i < 60; i++) begin
            run_frame();
            chk("run_frame", 1'b1, 1'b0, m_speed, m_score);
        end
        chk("schedule_end", 1'b1, 1'b0, 15, 60);

        // Crash and hold-off.
        hit();
        chk("crash", 1'b0, 1'b1, 15, 60);
        frame(1'b0, 1'b0);
        frame(1'b0, 1'b0);
        press();
        chk("hold_press_ignored", 1'b0, 1'b1, 15, 60);
        frame(1'b1, 1'b0);
        r_start = 1'b0;
        chk("hold_expiry_press_ignored", 1'b0, 1'b1, 15, 60);
        step();
        press();
        chk("rearm_keeps_score", 1'b0, 1'b0, 15, 60);
        frame(1'b0, 1'b0);
        chk("rerun_clears", 1'b1, 1'b0, 1, 0);
        model_enter_run();

        // Hit coincident with frame tick at score 9.
        for (int i = 0; i < 9; i++) run_frame();
        chk("score9", 1'b1, 1'b0, 3, 9);
        frame(1'b0, 1'b1);
        chk("hit_beats_tick", 1'b0, 1'b1, 3, 9);

        // Back into a run, build speed 5, then async reset mid-cycle.
        repeat (C_HOLD) frame(1'b0, 1'b0);
        press();
        frame(1'b0, 1'b0);
        model_enter_run();
        for (int i = 0; i < 16; i++) run_frame();
        chk("pre_reset", 1'b1, 1'b0, 5, 16);
        step();
        #1;
        rst_n = 1'b0;
        chk("async_reset", 1'b0, 1'b0, 1, 0, 1'b1, 1'b0);
        step();
        rst_n = 1'b1;
        step();

        // Held start: one run only, no auto-restart after crash.
        r_start = 1'b1;
        step();
        chk("held_armed", 1'b0, 1'b0, 1, 0);
        frame(1'b0, 1'b0);
        chk("held_run", 1'b1, 1'b0, 1, 0);
        hit();
        chk("held_crash", 1'b0, 1'b1, 1, 0);
        repeat (C_HOLD + 1) frame(1'b0, 1'b0);
        chk("held_no_restart", 1'b0, 1'b1, 1, 0);
        r_start = 1'b0;
        step();
        press();
        chk("release_then_press", 1'b0, 1'b0, 1, 0);

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 10 && sb.size() != 0; i++) step();
        if (sb.size() != 0) begin
            n_checks++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_game_sequencer
`default_nettype wire
